// File: rtl/gpr_rat_pkg.sv
// Shared constants, types and the address-width helper for the GPR + rename alias table.
// Optional commit-to-read forwarding is enabled by defining GPR_RAT_BYPASS_EN.
package gpr_rat_pkg;

    localparam int DEF_XLEN      = 32;
    localparam int DEF_NREGS     = 32;
    localparam int DEF_ROB_IDX_W = 4;
    localparam int DEF_NUM_RD    = 2;

    // Guard against a zero-width address when the file is shrunk to a single register.
    function automatic int gpr_addr_w(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    localparam int DEF_AW = gpr_addr_w(DEF_NREGS);

    typedef logic [DEF_AW-1:0]        reg_addr_t;
    typedef logic [DEF_ROB_IDX_W-1:0] rob_tag_t;

    typedef struct packed {
        logic     busy;
        rob_tag_t tag;
    } rat_entry_t;

endpackage

// File: rtl/gpr_rat_rd_port.sv
// One combinational read port: x0 masking, array select and, with GPR_RAT_BYPASS_EN,
// forwarding of a same-cycle tag-matching commit.
module gpr_rat_rd_port
    import gpr_rat_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int NREGS     = DEF_NREGS,
    parameter int ROB_IDX_W = DEF_ROB_IDX_W
) (
    input  logic [NREGS-1:0][XLEN-1:0]      data_vec,
    input  logic [NREGS-1:0]                busy_vec,
    input  logic [NREGS-1:0][ROB_IDX_W-1:0] tag_vec,
    input  logic [gpr_addr_w(NREGS)-1:0]    addr,
    input  logic                            cmt_valid,
    input  logic [gpr_addr_w(NREGS)-1:0]    cmt_addr,
    input  logic [ROB_IDX_W-1:0]            cmt_tag,
    input  logic [XLEN-1:0]                 cmt_wdata,
    output logic [XLEN-1:0]                 rdata,
    output logic                            busy,
    output logic [ROB_IDX_W-1:0]            tag
);

    logic is_x0;
    assign is_x0 = (addr == '0);

`ifdef GPR_RAT_BYPASS_EN
    logic fwd;
    assign fwd   = cmt_valid && !is_x0 && (addr == cmt_addr) && (tag_vec[addr] == cmt_tag);
    assign rdata = is_x0 ? '0 : (fwd ? cmt_wdata : data_vec[addr]);
    assign busy  = !is_x0 && !fwd && busy_vec[addr];
`else
    logic unused_cmt;
    assign unused_cmt = ^{cmt_valid, cmt_addr, cmt_tag, cmt_wdata};
    assign rdata = is_x0 ? '0 : data_vec[addr];
    assign busy  = !is_x0 && busy_vec[addr];
`endif

    assign tag = is_x0 ? '0 : tag_vec[addr];

endmodule

// File: rtl/gpr_rat.sv
// Architectural register file with per-register busy/tag alias table and busy counter.
// Define GPR_RAT_BYPASS_EN to forward same-cycle commits onto the read ports.
module gpr_rat
    import gpr_rat_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int NREGS     = DEF_NREGS,
    parameter int ROB_IDX_W = DEF_ROB_IDX_W,
    parameter int NUM_RD    = DEF_NUM_RD
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      ren_valid,
    input  logic [gpr_addr_w(NREGS)-1:0]              ren_rd_addr,
    input  logic [ROB_IDX_W-1:0]                      ren_tag,
    input  logic [NUM_RD-1:0][gpr_addr_w(NREGS)-1:0]  rs_addr,
    output logic [NUM_RD-1:0][XLEN-1:0]               rs_rdata,
    output logic [NUM_RD-1:0]                         rs_busy,
    output logic [NUM_RD-1:0][ROB_IDX_W-1:0]          rs_tag,
    input  logic                                      cmt_valid,
    input  logic [gpr_addr_w(NREGS)-1:0]              cmt_rd_addr,
    input  logic [ROB_IDX_W-1:0]                      cmt_tag,
    input  logic [XLEN-1:0]                           cmt_wdata,
    input  logic                                      flush,
    output logic [gpr_addr_w(NREGS):0]                busy_cnt
);

    localparam int AW = gpr_addr_w(NREGS);

    logic [XLEN-1:0]      data_q [NREGS];
    logic [XLEN-1:0]      data_d [NREGS];
    logic [ROB_IDX_W-1:0] tag_q  [NREGS];
    logic [ROB_IDX_W-1:0] tag_d  [NREGS];
    logic [NREGS-1:0]     busy_q, busy_d;
    logic [AW:0]          cnt_q, cnt_d;

    logic ren_ok, cmt_ok, cmt_hit, cnt_inc, cnt_dec;

    assign ren_ok  = ren_valid && !flush && (ren_rd_addr != '0);
    assign cmt_ok  = cmt_valid && (cmt_rd_addr != '0);
    assign cmt_hit = cmt_ok && busy_q[cmt_rd_addr] && (tag_q[cmt_rd_addr] == cmt_tag);
    assign cnt_inc = ren_ok && !busy_q[ren_rd_addr];
    // A same-register rename keeps the register busy, so a matching commit must not decrement.
    assign cnt_dec = cmt_hit && !(ren_ok && (ren_rd_addr == cmt_rd_addr));

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            data_d[r] = data_q[r];
            tag_d[r]  = tag_q[r];
        end
        busy_d = busy_q;

        if (cmt_ok) begin
            data_d[cmt_rd_addr] = cmt_wdata;
        end
        if (cmt_hit) begin
            busy_d[cmt_rd_addr] = 1'b0;
        end
        if (ren_ok) begin
            busy_d[ren_rd_addr] = 1'b1;
            tag_d[ren_rd_addr]  = ren_tag;
        end
        if (flush) begin
            busy_d = '0;
        end

        data_d[0] = '0;
        tag_d[0]  = '0;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                data_q[r] <= data_d[r];
                tag_q[r]  <= tag_d[r];
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

    logic [NREGS-1:0][XLEN-1:0]      data_vec;
    logic [NREGS-1:0][ROB_IDX_W-1:0] tag_vec;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            data_vec[r] = data_q[r];
            tag_vec[r]  = tag_q[r];
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        gpr_rat_rd_port #(
            .XLEN      (XLEN),
            .NREGS     (NREGS),
            .ROB_IDX_W (ROB_IDX_W)
        ) u_rd (
            .data_vec  (data_vec),
            .busy_vec  (busy_q),
            .tag_vec   (tag_vec),
            .addr      (rs_addr[p]),
            .cmt_valid (cmt_valid),
            .cmt_addr  (cmt_rd_addr),
            .cmt_tag   (cmt_tag),
            .cmt_wdata (cmt_wdata),
            .rdata     (rs_rdata[p]),
            .busy      (rs_busy[p]),
            .tag       (rs_tag[p])
        );
    end

endmodule

// File: tb/tb_gpr_rat.sv
// Randomized + directed bench for gpr_rat against an array-based reference model.
module tb_gpr_rat;
    import gpr_rat_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             ren_valid;
    logic [4:0]       ren_rd_addr;
    logic [3:0]       ren_tag;
    logic [1:0][4:0]  rs_addr;
    logic [1:0][31:0] rs_rdata;
    logic [1:0]       rs_busy;
    logic [1:0][3:0]  rs_tag;
    logic             cmt_valid;
    logic [4:0]       cmt_rd_addr;
    logic [3:0]       cmt_tag;
    logic [31:0]      cmt_wdata;
    logic             flush;
    logic [5:0]       busy_cnt;

    gpr_rat dut (
        .clk         (clk),
        .rst         (rst),
        .ren_valid   (ren_valid),
        .ren_rd_addr (ren_rd_addr),
        .ren_tag     (ren_tag),
        .rs_addr     (rs_addr),
        .rs_rdata    (rs_rdata),
        .rs_busy     (rs_busy),
        .rs_tag      (rs_tag),
        .cmt_valid   (cmt_valid),
        .cmt_rd_addr (cmt_rd_addr),
        .cmt_tag     (cmt_tag),
        .cmt_wdata   (cmt_wdata),
        .flush       (flush),
        .busy_cnt    (busy_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_data [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_cnt();
        int c = 0;
        for (int r = 1; r < 32; r++) c += m_busy[r] ? 1 : 0;
        return c;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_data[r] = '0;
            m_busy[r] = 1'b0;
            m_tag[r]  = '0;
        end
    endtask

    // One clock: drive at negedge, check reads before the edge, update model, check counter after.
    task automatic cyc(input logic rv, input logic [4:0] ra, input logic [3:0] rt,
                       input logic cv, input logic [4:0] ca, input logic [3:0] ct,
                       input logic [31:0] cd, input logic fl,
                       input logic [4:0] a0, input logic [4:0] a1);
        logic [4:0]  a;
        logic [31:0] ed;
        logic        eb;
        logic [3:0]  et;
        ren_valid = rv; ren_rd_addr = ra; ren_tag = rt;
        cmt_valid = cv; cmt_rd_addr = ca; cmt_tag = ct; cmt_wdata = cd;
        flush = fl; rs_addr[0] = a0; rs_addr[1] = a1;
        #1;
        for (int p = 0; p < 2; p++) begin
            a  = (p == 0) ? a0 : a1;
            ed = '0; eb = 1'b0; et = '0;
            if (a != 0) begin
                ed = m_data[a]; eb = m_busy[a]; et = m_tag[a];
`ifdef GPR_RAT_BYPASS_EN
                if (cv && ca == a && m_tag[a] == ct) begin
                    ed = cd; eb = 1'b0;
                end
`endif
            end
            chk($sformatf("rd%0d_data x%0d", p, a), 64'(rs_rdata[p]), 64'(ed));
            chk($sformatf("rd%0d_busy x%0d", p, a), 64'(rs_busy[p]), 64'(eb));
            if (eb) chk($sformatf("rd%0d_tag x%0d", p, a), 64'(rs_tag[p]), 64'(et));
        end
        @(posedge clk);
        if (cv && ca != 0) m_data[ca] = cd;
        if (fl) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        end else begin
            if (cv && ca != 0 && m_tag[ca] == ct) m_busy[ca] = 1'b0;
            if (rv && ra != 0) begin
                m_busy[ra] = 1'b1;
                m_tag[ra]  = rt;
            end
        end
        #1;
        chk("busy_cnt", 64'(busy_cnt), 64'(model_cnt()));
        @(negedge clk);
    endtask

    task automatic look(input string nm, input logic [4:0] a, input logic [31:0] d,
                        input logic b, input logic [3:0] t);
        ren_valid = 1'b0; cmt_valid = 1'b0; flush = 1'b0;
        rs_addr[0] = a; rs_addr[1] = 5'd0;
        #1;
        chk({nm, "_data"}, 64'(rs_rdata[0]), 64'(d));
        chk({nm, "_busy"}, 64'(rs_busy[0]), 64'(b));
        if (b) chk({nm, "_tag"}, 64'(rs_tag[0]), 64'(t));
        @(negedge clk);
    endtask

    initial begin
        reg_addr_t ra, ca, a0, a1;
        logic [3:0] ct;
        rst = 1'b1;
        ren_valid = 0; ren_rd_addr = 0; ren_tag = 0;
        cmt_valid = 0; cmt_rd_addr = 0; cmt_tag = 0; cmt_wdata = 0;
        flush = 0; rs_addr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("reset_cnt", 64'(busy_cnt), 64'd0);
        look("reset_x5", 5'd5, 32'h0, 1'b0, 4'h0);

        // rename then tag-matching commit clears busy
        cyc(1, 5'd3, 4'd2, 0, 5'd0, 4'd0, 32'h0, 0, 5'd3, 5'd0);
        chk("cnt_after_ren_x3", 64'(busy_cnt), 64'd1);
        cyc(0, 5'd0, 4'd0, 1, 5'd3, 4'd2, 32'h1234, 0, 5'd3, 5'd1);
        chk("cnt_after_cmt_x3", 64'(busy_cnt), 64'd0);
        look("x3_committed", 5'd3, 32'h1234, 1'b0, 4'h0);

        // older commit after a younger rename keeps busy/tag
        cyc(1, 5'd3, 4'd2, 0, 5'd0, 4'd0, 32'h0, 0, 5'd3, 5'd0);
        cyc(1, 5'd3, 4'd7, 0, 5'd0, 4'd0, 32'h0, 0, 5'd3, 5'd0);
        cyc(0, 5'd0, 4'd0, 1, 5'd3, 4'd2, 32'h55, 0, 5'd3, 5'd0);
        look("x3_stale_cmt", 5'd3, 32'h55, 1'b1, 4'd7);
        chk("cnt_stale_cmt", 64'(busy_cnt), 64'd1);

        // same-cycle rename and commit on x4: rename wins busy/tag
        cyc(1, 5'd4, 4'd0, 0, 5'd0, 4'd0, 32'h0, 0, 5'd4, 5'd0);
        cyc(1, 5'd4, 4'd1, 1, 5'd4, 4'd0, 32'h4444, 0, 5'd4, 5'd4);
        look("x4_ren_cmt", 5'd4, 32'h4444, 1'b1, 4'd1);

        // flush drops busy, drops concurrent rename, keeps commit data
        cyc(1, 5'd1, 4'd3, 0, 5'd0, 4'd0, 32'h0, 0, 5'd1, 5'd2);
        cyc(1, 5'd2, 4'd4, 0, 5'd0, 4'd0, 32'h0, 0, 5'd2, 5'd9);
        cyc(1, 5'd9, 4'd5, 0, 5'd0, 4'd0, 32'h0, 0, 5'd9, 5'd1);
        cyc(1, 5'd10, 4'd6, 1, 5'd2, 4'd9, 32'h77, 1, 5'd10, 5'd2);
        chk("cnt_after_flush", 64'(busy_cnt), 64'd0);
        look("x2_flush", 5'd2, 32'h77, 1'b0, 4'h0);
        look("x10_flush", 5'd10, 32'h0, 1'b0, 4'h0);
        look("x9_flush", 5'd9, 32'h0, 1'b0, 4'h0);

        // x0 ignores rename and commit
        cyc(1, 5'd0, 4'd3, 1, 5'd0, 4'd0, 32'hFFFF, 0, 5'd0, 5'd0);
        look("x0", 5'd0, 32'h0, 1'b0, 4'h0);

        // commit to x6 while reading it
        cyc(1, 5'd6, 4'd3, 0, 5'd0, 4'd0, 32'h0, 0, 5'd6, 5'd0);
        ren_valid = 0; flush = 0;
        cmt_valid = 1; cmt_rd_addr = 5'd6; cmt_tag = 4'd3; cmt_wdata = 32'hAB;
        rs_addr[0] = 5'd6;
        #1;
`ifdef GPR_RAT_BYPASS_EN
        chk("x6_bypass_data", 64'(rs_rdata[0]), 64'hAB);
        chk("x6_bypass_busy", 64'(rs_busy[0]), 64'd0);
`else
        chk("x6_nobypass_data", 64'(rs_rdata[0]), 64'h0);
        chk("x6_nobypass_busy", 64'(rs_busy[0]), 64'd1);
`endif
        @(negedge clk);
        m_data[6] = 32'hAB; m_busy[6] = 1'b0;
        look("x6_after", 5'd6, 32'hAB, 1'b0, 4'h0);

        // asynchronous reset in mid-run with x5 busy and holding 0xDEAD
        cyc(1, 5'd5, 4'd4, 0, 5'd0, 4'd0, 32'h0, 0, 5'd5, 5'd0);
        cyc(0, 5'd0, 4'd0, 1, 5'd5, 4'd1, 32'hDEAD, 0, 5'd5, 5'd6);
        rs_addr[0] = 5'd5; rs_addr[1] = 5'd6;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_rdata0", 64'(rs_rdata[0]), 64'd0);
        chk("rst_busy0", 64'(rs_busy[0]), 64'd0);
        chk("rst_tag0", 64'(rs_tag[0]), 64'd0);
        chk("rst_rdata1", 64'(rs_rdata[1]), 64'd0);
        chk("rst_cnt", 64'(busy_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        look("x5_post_rst", 5'd5, 32'h0, 1'b0, 4'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            ra = reg_addr_t'($urandom_range(0, 31));
            ca = reg_addr_t'($urandom_range(0, 31));
            ct = ($urandom_range(0, 1) == 1) ? m_tag[ca] : 4'($urandom);
            a0 = ($urandom_range(0, 3) == 0) ? ca : reg_addr_t'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? ra : reg_addr_t'($urandom_range(0, 31));
            cyc(1'($urandom_range(0, 2) != 0), ra, 4'($urandom),
                1'($urandom_range(0, 2) != 0), ca, ct, $urandom,
                1'($urandom_range(0, 19) == 0), a0, a1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
